// File: rtl/ebpf_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ebpf_mem_pkg
// Brief   : Size encodings, clear-FSM state type and lane helpers for the
//           eBPF data memory.
// Revision: 1.0
// ============================================================================
package ebpf_mem_pkg;

    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;
    localparam logic [1:0] SZ_DW = 2'b11;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Low address bits that must be zero for an access of this size.
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ebpf_bytelane_ram.sv
`default_nettype none
// ============================================================================
// Module  : ebpf_bytelane_ram
// Brief   : Single-port 64-bit synchronous RAM with eight byte-lane enables.
// Revision: 1.0
// ============================================================================
module ebpf_bytelane_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [7:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       wdata_i,
    output logic [63:0]       rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;

    // Read data only updates on a load, so it holds between loads.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 8; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ebpf_data_mem.sv
`default_nettype none
// ============================================================================
// Module  : ebpf_data_mem
// Brief   : eBPF byte-addressable data memory with post-reset clear sequencer.
//           Define DMEM_MISALIGN_CHECK_EN to fault misaligned accesses instead
//           of masking the address down to size alignment.
// Revision: 1.0
// ============================================================================
module ebpf_data_mem
    import ebpf_mem_pkg::*;
#(
    parameter int WORD_ADDR_W    = 11,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stb,
    input  logic                   we,
    input  logic [1:0]             size,
    input  logic [WORD_ADDR_W+2:0] adr,
    input  logic [63:0]            dat_w,
    output logic [63:0]            dat_r,
    output logic                   ack,
    output logic                   err,
    output logic                   busy
);
    localparam int                     DEPTH         = 2 ** WORD_ADDR_W;
    localparam logic [WORD_ADDR_W-1:0] C_LAST_WORD   = WORD_ADDR_W'(DEPTH - 1);
    localparam logic [WORD_ADDR_W-1:0] C_CNT_ONE     = WORD_ADDR_W'(1);
    localparam state_e                 C_RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e                 state_q, state_d;
    logic [WORD_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic                   ack_q, err_q, ld_q;
    logic [2:0]             off_q;
    logic [1:0]             size_q;
    logic [63:0]            hold_q;

    logic                   w_accept, w_fault;
    logic [2:0]             w_amask, w_off;
    logic [7:0]             w_be, w_ld_lanes;
    logic [63:0]            w_wdata, w_lane_bits, w_ram_rdata, w_ext;

    logic                   ram_en, ram_we;
    logic [7:0]             ram_be;
    logic [WORD_ADDR_W-1:0] ram_addr;
    logic [63:0]            ram_wdata;

    assign busy     = (state_q == ST_CLEAR);
    assign w_accept = stb && !busy;
    assign w_amask  = align_mask(size);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_fault = |(adr[2:0] & w_amask);
    assign w_off   = adr[2:0];
`else
    assign w_fault = 1'b0;
    assign w_off   = adr[2:0] & ~w_amask;
`endif

    assign w_be    = lane_mask(size) << w_off;
    assign w_wdata = dat_w << {w_off, 3'b000};

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + C_CNT_ONE;
                if (clr_cnt_q == C_LAST_WORD) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // The clear sequencer owns the RAM port while busy; requests are dropped.
    always_comb begin
        ram_en    = w_accept && !w_fault;
        ram_we    = we;
        ram_be    = w_be;
        ram_addr  = adr[WORD_ADDR_W+2:3];
        ram_wdata = w_wdata;
        if (busy) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_be    = 8'hFF;
            ram_addr  = clr_cnt_q;
            ram_wdata = '0;
        end
    end

    ebpf_bytelane_ram #(
        .ADDR_W (WORD_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    assign w_ld_lanes = lane_mask(size_q);

    for (genvar g = 0; g < 8; g++) begin : g_lane_bits
        assign w_lane_bits[8*g +: 8] = {8{w_ld_lanes[g]}};
    end

    assign w_ext = (w_ram_rdata >> {off_q, 3'b000}) & w_lane_bits;

    always_comb begin
        dat_r = hold_q;
        if (ack_q) begin
            if (err_q) begin
                dat_r = '0;
            end else if (ld_q) begin
                dat_r = w_ext;
            end
        end
    end

    assign ack = ack_q;
    assign err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= C_RESET_STATE;
            clr_cnt_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ld_q      <= 1'b0;
            off_q     <= '0;
            size_q    <= SZ_B;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ack_q     <= w_accept;
            err_q     <= w_accept && w_fault;
            if (w_accept) begin
                ld_q   <= !we;
                off_q  <= w_off;
                size_q <= size;
            end
            if (ack_q) begin
                hold_q <= dat_r;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ebpf_data_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_ebpf_data_mem
// Brief   : Scoreboard bench for ebpf_data_mem against a byte-array model.
// Revision: 1.0
// ============================================================================
module tb_ebpf_data_mem;
    import ebpf_mem_pkg::*;

    localparam int AW     = 11;
    localparam int NBYTES = 8 * (2 ** AW);
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb   = 1'b0;
    logic          we    = 1'b0;
    logic [1:0]    size  = 2'b00;
    logic [AW+2:0] adr   = '0;
    logic [63:0]   dat_w = '0;
    logic [63:0]   dat_r;
    logic          ack, err, busy;

    ebpf_data_mem #(
        .WORD_ADDR_W    (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stb   (stb),
        .we    (we),
        .size  (size),
        .adr   (adr),
        .dat_w (dat_w),
        .dat_r (dat_r),
        .ack   (ack),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_pop;
    logic [7:0]  mem_m [NBYTES];
    logic [63:0] last_m   = '0;
    logic [63:0] hold_exp = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ack = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Model: byte array, size-aligned addressing, right-aligned zero-extended loads.
    task automatic send(input bit w, input logic [1:0] sz, input logic [AW+2:0] a,
                        input logic [63:0] d);
        int          n;
        int          base;
        exp_t        e;
        logic [63:0] v;
        n   = 1 << sz;
        e.e = 1'b0;
        if (MIS_EN && ((int'(a) % n) != 0)) begin
            e.e    = 1'b1;
            e.d    = '0;
            last_m = '0;
        end else begin
            base = int'(a) - (int'(a) % n);
            if (w) begin
                for (int i = 0; i < n; i++) mem_m[base + i] = d[8*i +: 8];
                e.d = last_m;
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[base + i];
                last_m = v;
                e.d    = v;
            end
        end
        exp_q.push_back(e);
        stb   = 1'b1;
        we    = w;
        size  = sz;
        adr   = a;
        dat_w = d;
        @(posedge clk);
        #1;
        stb = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NBYTES; i++) mem_m[i] = '0;
        last_m = '0;
    endtask

    // Counts negedge samples with busy high; optionally fires requests that must drop.
    task automatic count_busy(output int cnt, input bit poke);
        cnt = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (poke) begin
                stb   = 1'b1;
                we    = 1'($urandom_range(0, 1));
                size  = 2'($urandom_range(0, 3));
                adr   = 14'h10;
                dat_w = {$urandom, $urandom};
            end
        end
        stb = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_exp = '0;
        end else if (ack) begin
            n_ack++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack=1 expected ack=0");
            end else begin
                e_pop = exp_q.pop_front();
                chk("ack_dat_r", dat_r, e_pop.d);
                chk("ack_err", 64'(err), 64'(e_pop.e));
                hold_exp = e_pop.d;
            end
        end else begin
            chk("idle_hold_dat_r", dat_r, hold_exp);
            chk("idle_err", 64'(err), 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            nb;
        int            a0;
        bit            w;
        logic [1:0]    sz;
        logic [AW+2:0] a;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_dat_r", dat_r, 64'd0);
        rst_n = 1'b1;

        count_busy(nb, 1'b0);
        chk("clear_busy_cycles", 64'(nb), 64'd2048);
        clear_model();
        @(posedge clk);
        #1;

        send(1'b0, SZ_DW, 14'h3FF8, 64'd0);
        chk("clear_top_dword", dat_r, 64'd0);

        send(1'b1, SZ_DW, 14'h10, 64'h1122334455667788);
        send(1'b1, SZ_B,  14'h13, 64'hAA);
        send(1'b0, SZ_DW, 14'h10, 64'd0);
        chk("bytelane_dword", dat_r, 64'h11223344AA667788);
        send(1'b0, SZ_H,  14'h16, 64'd0);
        chk("ext_half", dat_r, 64'h0000000000001122);
        send(1'b0, SZ_B,  14'h17, 64'd0);
        chk("ext_byte", dat_r, 64'h11);

        send(1'b1, SZ_W, 14'h20, 64'hDEADBEEF);
        chk("b2b_ack_store", 64'(ack), 64'd1);
        send(1'b0, SZ_W, 14'h20, 64'd0);
        chk("b2b_ack_load", 64'(ack), 64'd1);
        chk("b2b_load_data", dat_r, 64'hDEADBEEF);

        send(1'b1, SZ_W, 14'h22, 64'h0BADF00D);
        chk("misalign_err", 64'(err), 64'(MIS_EN));
        send(1'b0, SZ_DW, 14'h20, 64'd0);
        chk("misalign_mem", dat_r, MIS_EN ? 64'hDEADBEEF : 64'h0BADF00D);

        for (int k = 0; k < 400; k++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 14'(14'h3F80 + $urandom_range(0, 127));
            else                           a = 14'($urandom_range(0, 127));
            send(w, sz, a, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("drain_run", 64'(exp_q.size()), 64'd0);

        rst_n = 1'b0;
        last_m = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst2_dat_r", dat_r, 64'd0);
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        chk("busy_at_500", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midclear_rst_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        a0 = n_ack;
        count_busy(nb, 1'b1);
        chk("restart_busy_cycles", 64'(nb), 64'd2048);
        chk("dropped_no_ack", 64'(n_ack - a0), 64'd0);
        clear_model();
        @(posedge clk);
        #1;

        send(1'b0, SZ_DW, 14'h10, 64'd0);
        chk("restart_cleared_0x10", dat_r, 64'd0);
        send(1'b0, SZ_DW, 14'h3FF8, 64'd0);
        send(1'b1, SZ_H, 14'h3FFE, 64'hBEEF);
        send(1'b0, SZ_DW, 14'h3FF8, 64'd0);
        chk("top_half_store", dat_r, 64'hBEEF000000000000);

        repeat (2) @(posedge clk);
        #1;
        chk("drain_end", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
